// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between requesters, the arbiter and the FIFO.
// slave = arbiter side, master = producers/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) ();
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ-1:0]       last;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic                     fifo_full;
   logic [NUM_REQ-1:0]       gnt;
   logic [OW-1:0]            owner;
   logic                     busy;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_wr_data;

   modport slave (
      input  req, last, req_data, fifo_full,
      output gnt, owner, busy, fifo_wr_en, fifo_wr_data
   );

   modport master (
      output req, last, req_data, fifo_full,
      input  gnt, owner, busy, fifo_wr_en, fifo_wr_data
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter for one FIFO write port.
// Define FIFO_ARB_PRIO_EN to make requester 0 high priority.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 8
) (
   input logic                clk,
   input logic                rst,
   fifo_wr_arbiter_if.slave   bus
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [OW-1:0]      r_owner;
   logic [OW-1:0]      r_rr_ptr;
   logic               r_busy;
   logic [CW-1:0]      r_beat_cnt;

   logic               w_own_req;
   logic               w_own_last;
   logic               w_beat;
   logic               w_burst_end;
   logic               w_release;
   logic               w_found;
   logic [OW-1:0]      w_win;
   int                 w_idx;

   assign w_own_req   = bus.req[r_owner];
   assign w_own_last  = bus.last[r_owner];
   // rst gates the strobe so nothing is written on the reset edge
   assign w_beat      = (r_state == S_LOCKED) && w_own_req
                        && !bus.fifo_full && !rst;
   assign w_burst_end = (r_beat_cnt == CW'(MAX_BURST - 1));
   assign w_release   = !w_own_req
                        || (w_beat && (w_own_last || w_burst_end));

   assign bus.fifo_wr_en   = w_beat;
   assign bus.fifo_wr_data =
      WIDTH'(bus.req_data >> (int'(r_owner) * WIDTH));
   assign bus.gnt   = r_gnt;
   assign bus.owner = r_owner;
   assign bus.busy  = r_busy;

   // Walk downward so the nearest requester after rr_ptr wins last
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (bus.req[OW'(w_idx)]) begin
            w_win   = OW'(w_idx);
            w_found = 1'b1;
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (bus.req[0]) begin
         w_win   = '0;
         w_found = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_owner    <= '0;
         r_busy     <= 1'b0;
         r_beat_cnt <= '0;
         r_rr_ptr   <= OW'(NUM_REQ - 1);
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state    <= S_LOCKED;
                  r_gnt      <= NUM_REQ'(1) << w_win;
                  r_owner    <= w_win;
                  r_busy     <= 1'b1;
                  r_beat_cnt <= '0;
               end else begin
                  r_gnt <= '0;
               end
            end
            S_LOCKED: begin
               if (w_beat)
                  r_beat_cnt <= r_beat_cnt + CW'(1);
               if (w_release) begin
                  r_state <= S_IDLE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
`ifdef FIFO_ARB_PRIO_EN
                  // the priority requester leaves the rotation untouched
                  if (r_owner != '0)
                     r_rr_ptr <= r_owner;
`else
                  r_rr_ptr <= r_owner;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed packet scenarios then random traffic,
// checked against a per-cycle behavioural model of the grant rules.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // model: m_own = -1 when nobody holds the port
   int m_own  = -1;
   int m_last = 0;
   int m_ptr  = N - 1;
   int m_cnt  = 0;

   int wr_cnt = 0;
   logic [W-1:0] wq[$];
   int oq[$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setd(int i, logic [W-1:0] v);
      logic [N*W-1:0] m;
      m = (N*W)'(8'hFF) << (i * W);
      bus.req_data = (bus.req_data & ~m) | ((N*W)'(v) << (i * W));
   endtask

   function automatic bit bit_of(int vec, int i);
      return ((vec >> i) & 1) == 1;
   endfunction

   function automatic int pick(int r);
      int w = -1;
`ifdef FIFO_ARB_PRIO_EN
      if (bit_of(r, 0)) return 0;
`endif
      for (int k = 1; k <= N; k++)
         if (w < 0 && bit_of(r, (m_ptr + k) % N)) w = (m_ptr + k) % N;
      return w;
   endfunction

   task automatic rel();
`ifdef FIFO_ARB_PRIO_EN
      if (m_own != 0) m_ptr = m_own;
`else
      m_ptr = m_own;
`endif
      m_own = -1;
   endtask

   task automatic step();
      int ri, li, w;
      logic exp_wr;
      logic [W-1:0] exp_d;
      #1;
      ri = int'(bus.req);
      li = int'(bus.last);
      exp_wr = !rst && m_own >= 0 && bit_of(ri, m_own) && !bus.fifo_full;
      chk("wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
      if (exp_wr) begin
         exp_d = W'(bus.req_data >> (m_own * W));
         chk("wr_data", 32'(bus.fifo_wr_data), 32'(exp_d));
      end
      if (bus.fifo_wr_en) begin
         wr_cnt++;
         wq.push_back(bus.fifo_wr_data);
      end
      if (rst) begin
         m_own = -1; m_last = 0; m_ptr = N - 1; m_cnt = 0;
      end else if (m_own < 0) begin
         w = pick(ri);
         if (w >= 0) begin
            m_own = w; m_last = w; m_cnt = 0;
         end
      end else if (!bit_of(ri, m_own)) begin
         rel();
      end else if (exp_wr) begin
         m_cnt++;
         if (bit_of(li, m_own) || m_cnt == MB) rel();
      end
      @(posedge clk);
      #1;
      chk("gnt", 32'(bus.gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
      chk("owner", 32'(bus.owner), 32'(m_last));
      chk("busy", 32'(bus.busy), 32'(m_own >= 0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.last = '0;
      bus.fifo_full = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bus.req = '0;
      bus.last = '0;
      bus.req_data = '0;
      bus.fifo_full = 1'b0;

      // reset values
      do_reset();
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_owner", 32'(bus.owner), 0);
      chk("rst_busy", 32'(bus.busy), 0);

      // single 3-beat packet from requester 0
      bus.req = 4'b0001;
      setd(0, 8'hA1);
      step();
      chk("t1_gnt", 32'(bus.gnt), 32'h1);
      wr_cnt = 0; wq.delete();
      step();
      setd(0, 8'hA2); step();
      setd(0, 8'hA3); bus.last = 4'b0001; step();
      bus.req = '0; bus.last = '0;
      chk("t1_rel_gnt", 32'(bus.gnt), 0);
      chk("t1_owner", 32'(bus.owner), 0);
      chk("t1_writes", 32'(wr_cnt), 3);
      for (int i = 0; i < 3; i++)
         chk("t1_data", 32'(wq[i]), 32'(8'hA1 + i));

      // everyone requesting, single-beat packets
      do_reset();
      bus.req = 4'b1111; bus.last = 4'b1111;
      oq.delete();
      for (int i = 0; i < 10; i++) begin
         bit pb;
         pb = bus.busy;
         for (int r = 0; r < N; r++) setd(r, W'($urandom));
         step();
         if (bus.busy && !pb) oq.push_back(int'(bus.owner));
      end
      chk("t2_grants", 32'(oq.size()), 5);
      for (int i = 0; i < oq.size() && i < 5; i++)
         chk("t2_order", 32'(oq[i]), 32'(i % N));

      // 12-beat packet broken at MAX_BURST
      do_reset();
      bus.req = 4'b0100; bus.last = '0;
      wr_cnt = 0;
      begin
         int rel_at = -1;
         for (int i = 0; i < 40 && wr_cnt < 12; i++) begin
            setd(2, W'(8'h30 + wr_cnt));
            if (wr_cnt == 11) bus.last = 4'b0100;
            step();
            if (!bus.busy && rel_at < 0 && wr_cnt > 0) rel_at = wr_cnt;
         end
         chk("t3_burst", 32'(rel_at), MB);
      end
      chk("t3_total", 32'(wr_cnt), 12);
      chk("t3_rel", 32'(bus.busy), 0);
      bus.req = '0; bus.last = '0;
      step();

      // fifo_full stall mid-packet
      do_reset();
      bus.req = 4'b0010;
      setd(1, 8'h20); step();
      wr_cnt = 0; wq.delete();
      step();
      setd(1, 8'h21); step();
      setd(1, 8'h22); bus.fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_hold_gnt", 32'(bus.gnt), 32'h2);
         chk("t4_hold_wr", 32'(bus.fifo_wr_en), 0);
      end
      bus.fifo_full = 1'b0;
      step();
      setd(1, 8'h23); bus.last = 4'b0010; step();
      bus.req = '0; bus.last = '0;
      chk("t4_writes", 32'(wr_cnt), 4);
      for (int i = 0; i < 4 && i < wq.size(); i++)
         chk("t4_data", 32'(wq[i]), 32'(8'h20 + i));

      // owner 3 abandons after two beats
      do_reset();
      bus.req = 4'b1000; step();
      bus.req = 4'b1011;
      wr_cnt = 0;
      step(); step();
      bus.req = 4'b0011;
      step();
      chk("t5_abandon_writes", 32'(wr_cnt), 2);
      chk("t5_rel_gnt", 32'(bus.gnt), 0);
      step();
      chk("t5_next_gnt", 32'(bus.gnt), 32'h1);
      chk("t5_next_owner", 32'(bus.owner), 0);
      bus.req = '0; step(); step();

      // reset while locked
      do_reset();
      bus.req = 4'b0010; step(); step();
      rst = 1'b1;
      #1;
      chk("t6_rst_wr", 32'(bus.fifo_wr_en), 0);
      step();
      chk("t6_gnt", 32'(bus.gnt), 0);
      chk("t6_owner", 32'(bus.owner), 0);
      chk("t6_busy", 32'(bus.busy), 0);
      rst = 1'b0;

      // requester 0 packet, then contention with requester 1
      bus.req = 4'b0001; bus.last = 4'b0001;
      step(); step();
      bus.req = 4'b1011; bus.last = '0;
      step();
`ifdef FIFO_ARB_PRIO_EN
      chk("t7_winner", 32'(bus.owner), 0);
`else
      chk("t7_winner", 32'(bus.owner), 1);
`endif
      bus.req = '0; step(); step();

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] r, l;
         for (int b = 0; b < N; b++) begin
            r[b] = ($urandom_range(0, 9) < 6);
            l[b] = ($urandom_range(0, 3) == 0);
         end
         bus.req = r;
         bus.last = l;
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         bus.req_data = (N*W)'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
